ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Microcoded control sequencer for the 8-bit-address processor. It sits directly upstream of the program counter. It generates the counter's `pc_inc`, `load_pc` and `pc_oen` strobes, plus the bus, memory, accumulator and output-register strobes that run fetch, decode and execute. It holds the instruction register internally, and its outputs are Moore decodes of a multi-cycle state machine.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single system clock; all state changes on rising edge.
- `clr` in 1: reset, asynchronous, active-low.
- `run` in 1: level; 1 = execute, 0 = stop at next instruction boundary.
- `mem_data` in 8: memory read data (bus value while `mem_oen`=1).
- `zero_flag` in 1: registered accumulator zero flag from datapath.
- `carry_flag` in 1: registered ALU carry/borrow flag from datapath.
- `pc_inc` out 1: program counter increment.
- `load_pc` out 1: program counter parallel load from bus.
- `pc_oen` out 1: program counter drives bus.
- `mar_load` out 1: memory address register loads from bus.
- `mem_oen` out 1: memory drives bus.
- `acc_load` out 1: accumulator loads ALU result.
- `alu_op` out 2: 00 pass bus, 01 add, 10 subtract, 11 unused.
- `acc_oen` out 1: accumulator drives bus.
- `out_load` out 1: output port register loads from bus.
- `ir` out 8: current instruction register contents.
- `halted` out 1: 1 while in HALT.

## Operation
- States: IDLE, F0, F1, DEC, A0, A1, M0, XO, HALT.
- Opcode = `ir[7:4]`. Decode:
  - 0 NOP
  - 1 LDA a
  - 2 ADD a
  - 3 SUB a
  - 4 OUT
  - 5 JMP a
  - 6 JZ a
  - 7 JC a
  - F HLT
  - all other opcodes execute as NOP.
- Two-byte instructions (1,2,3,5,6,7) carry address byte `a` in the next memory word.
- IDLE: no strobes. Go to F0 when `run`=1, else stay.
- F0: `pc_oen`, `mar_load`. Go to F1.
- F1: `mem_oen`, `pc_inc`. `ir` ← `mem_data`. Go to DEC.
- DEC: no strobes.
  - NOP → boundary.
  - HLT → HALT.
  - OUT → XO.
  - Two-byte → A0.
- A0: `pc_oen`, `mar_load`. Go to A1.
- A1: `mem_oen`, plus:
  - LDA/ADD/SUB: `mar_load`, `pc_inc`. Go to M0.
  - JMP, JZ with `zero_flag`=1, JC with `carry_flag`=1: `load_pc` only, no `pc_inc`. Go to boundary.
  - JZ/JC not taken: `pc_inc` only. Go to boundary.
- M0: `mem_oen`, `acc_load`. `alu_op` = 00 (LDA) / 01 (ADD) / 10 (SUB). Go to boundary.
- XO: `acc_oen`, `out_load`. Go to boundary.
- Boundary transition: to F0 if `run`=1, else to IDLE.
- HALT: `halted`=1, no other strobes. Held until `clr`; `run` is ignored.
- Invariants, every cycle:
  - At most one of `pc_oen`, `mem_oen`, `acc_oen` is 1.
  - `pc_inc` and `load_pc` are never both 1.
  - `alu_op`=00 whenever `acc_load`=0.

## Timing
- Reset (`clr`=0, asynchronous, effective mid-instruction): state IDLE, `ir`=00h, all strobes 0, `alu_op`=00, `halted`=0. Release is sampled at the next `clk` edge.
- Outputs are combinational from the state register (and from `ir`/flags in A1). They are valid within the same cycle as the state.
- Flags are sampled only in A1. They reflect the accumulator result of the previous instruction.
- Cycles per instruction, from entering F0 to the next F0:
  - NOP 3
  - OUT 4
  - JMP/JZ/JC 5
  - LDA/ADD/SUB 6
  - HLT reaches HALT 3 cycles after F0.
- `run` is sampled only in IDLE and at the boundary. Deasserting it mid-instruction completes the instruction, then parks in IDLE.
- `run`=1 while in IDLE: F0 on the next edge, so the first fetch strobe appears 1 cycle after `run` rises.

## Test plan
- Reset mid-F1 with `mem_data`=5Ah: `ir` stays 00h, all outputs 0 immediately. After release with `run`=1, F0 strobes (`pc_oen`, `mar_load`) appear on the second edge.
- Fetch/NOP, memory 00h,00h, `run`=1: repeating 3-cycle pattern `pc_oen`+`mar_load` / `mem_oen`+`pc_inc` / idle. `pc_inc` pulses once per 3 cycles.
- LDA 10h then ADD 10h:
  - 6 cycles each.
  - `pc_inc` exactly twice per instruction.
  - M0 shows `acc_load` with `alu_op`=00, then `acc_load` with `alu_op`=01.
  - `mar_load` asserted in F0, A0, A1.
- JZ with `zero_flag`=1, then with `zero_flag`=0:
  - Taken: `load_pc`=1 and `pc_inc`=0 in A1.
  - Not taken: `pc_inc`=1 and `load_pc`=0.
  - Both take 5 cycles.
- HLT (F0h): `halted`=1 from cycle 3 onward, with no strobes for 20 cycles while `run` toggles. Reset clears `halted`.
- `run` dropped during M0 of a SUB: M0 completes with `alu_op`=10, next state IDLE, no F0 strobes until `run` returns.
- Whole-run assertion in all tests: bus-driver one-hot and `pc_inc`/`load_pc` exclusivity never violated.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// rtl/ctrl_seq_if.sv - strobe and status bundle between ctrl_seq and the datapath
//
// Purpose : groups every ctrl_seq signal except clock and reset.
// Signals : run, mem_data, zero_flag, carry_flag      datapath -> sequencer
//           pc_inc, load_pc, pc_oen, mar_load,        sequencer -> datapath
//           mem_oen, acc_load, alu_op[1:0], acc_oen,
//           out_load, ir[7:0], halted
// Modports: master = sequencer side, slave = datapath side.

interface ctrl_seq_if;
   logic       run;
   logic [7:0] mem_data;
   logic       zero_flag;
   logic       carry_flag;
   logic       pc_inc;
   logic       load_pc;
   logic       pc_oen;
   logic       mar_load;
   logic       mem_oen;
   logic       acc_load;
   logic [1:0] alu_op;
   logic       acc_oen;
   logic       out_load;
   logic [7:0] ir;
   logic       halted;

   modport master (
      input  run, mem_data, zero_flag, carry_flag,
      output pc_inc, load_pc, pc_oen, mar_load, mem_oen, acc_load,
             alu_op, acc_oen, out_load, ir, halted
   );

   modport slave (
      output run, mem_data, zero_flag, carry_flag,
      input  pc_inc, load_pc, pc_oen, mar_load, mem_oen, acc_load,
             alu_op, acc_oen, out_load, ir, halted
   );
endinterface

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - microcoded fetch/decode/execute sequencer
//
// Purpose : multi-cycle Moore FSM that produces program counter, bus,
//           memory, accumulator and output-register strobes for the
//           8-bit-address processor; holds the instruction register.
// Ports   : clk      - system clock, rising edge
//           clr      - asynchronous active-low reset
//           seq_bus  - ctrl_seq_if.master (inputs run/mem_data/flags,
//                      outputs all strobes, alu_op, ir, halted)

module ctrl_seq (
   input  logic       clk,
   input  logic       clr,
   ctrl_seq_if.master seq_bus
);

   localparam logic [3:0] IDLE = 4'd0;
   localparam logic [3:0] F0   = 4'd1;
   localparam logic [3:0] F1   = 4'd2;
   localparam logic [3:0] DEC  = 4'd3;
   localparam logic [3:0] A0   = 4'd4;
   localparam logic [3:0] A1   = 4'd5;
   localparam logic [3:0] M0   = 4'd6;
   localparam logic [3:0] XO   = 4'd7;
   localparam logic [3:0] HALT = 4'd8;

   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_OUT = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JZ  = 4'h6;
   localparam logic [3:0] OP_JC  = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   logic [3:0] r_state;
   logic [3:0] w_next;
   logic [7:0] r_ir;
   logic [3:0] w_op;
   logic       w_mem_op;
   logic       w_two_byte;
   logic       w_taken;
   logic [3:0] w_boundary;

   assign w_op       = r_ir[7:4];
   assign w_mem_op   = (w_op == OP_LDA) || (w_op == OP_ADD) || (w_op == OP_SUB);
   assign w_two_byte = w_mem_op || (w_op == OP_JMP) || (w_op == OP_JZ) || (w_op == OP_JC);
   // Flags are only meaningful in A1, where this term is consumed.
   assign w_taken    = (w_op == OP_JMP)
                    || ((w_op == OP_JZ) && seq_bus.zero_flag)
                    || ((w_op == OP_JC) && seq_bus.carry_flag);
   // run is only looked at when an instruction finishes.
   assign w_boundary = seq_bus.run ? F0 : IDLE;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: w_next = seq_bus.run ? F0 : IDLE;
         F0:   w_next = F1;
         F1:   w_next = DEC;
         DEC: begin
            if (w_op == OP_HLT)      w_next = HALT;
            else if (w_op == OP_OUT) w_next = XO;
            else if (w_two_byte)     w_next = A0;
            else                     w_next = w_boundary;
         end
         A0:   w_next = A1;
         A1:   w_next = w_mem_op ? M0 : w_boundary;
         M0:   w_next = w_boundary;
         XO:   w_next = w_boundary;
         HALT: w_next = HALT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= IDLE;
         r_ir    <= 8'h00;
      end else begin
         r_state <= w_next;
         if (r_state == F1) r_ir <= seq_bus.mem_data;
      end
   end

   always_comb begin
      seq_bus.pc_inc   = 1'b0;
      seq_bus.load_pc  = 1'b0;
      seq_bus.pc_oen   = 1'b0;
      seq_bus.mar_load = 1'b0;
      seq_bus.mem_oen  = 1'b0;
      seq_bus.acc_load = 1'b0;
      seq_bus.alu_op   = 2'b00;
      seq_bus.acc_oen  = 1'b0;
      seq_bus.out_load = 1'b0;
      seq_bus.halted   = 1'b0;
      case (r_state)
         F0, A0: begin
            seq_bus.pc_oen   = 1'b1;
            seq_bus.mar_load = 1'b1;
         end
         F1: begin
            seq_bus.mem_oen = 1'b1;
            seq_bus.pc_inc  = 1'b1;
         end
         A1: begin
            // Address byte is on the bus: it goes to the MAR for memory
            // operands, or to the PC for a taken jump.
            seq_bus.mem_oen = 1'b1;
            if (w_mem_op) begin
               seq_bus.mar_load = 1'b1;
               seq_bus.pc_inc   = 1'b1;
            end else if (w_taken) begin
               seq_bus.load_pc  = 1'b1;
            end else begin
               seq_bus.pc_inc   = 1'b1;
            end
         end
         M0: begin
            seq_bus.mem_oen  = 1'b1;
            seq_bus.acc_load = 1'b1;
            case (w_op)
               OP_ADD:  seq_bus.alu_op = 2'b01;
               OP_SUB:  seq_bus.alu_op = 2'b10;
               default: seq_bus.alu_op = 2'b00;
            endcase
         end
         XO: begin
            seq_bus.acc_oen  = 1'b1;
            seq_bus.out_load = 1'b1;
         end
         HALT: seq_bus.halted = 1'b1;
         default: ;
      endcase
   end

   assign seq_bus.ir = r_ir;

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard bench for ctrl_seq

module tb_ctrl_seq;

   // Expected strobe vector bits:
   // {halted, pc_inc, load_pc, pc_oen, mar_load, mem_oen, acc_load, alu_op[1:0], acc_oen, out_load}
   localparam logic [10:0] NONE   = 11'h000;
   localparam logic [10:0] B_HALT = 11'h400;
   localparam logic [10:0] B_INC  = 11'h200;
   localparam logic [10:0] B_LDPC = 11'h100;
   localparam logic [10:0] B_PCOE = 11'h080;
   localparam logic [10:0] B_MAR  = 11'h040;
   localparam logic [10:0] B_MEM  = 11'h020;
   localparam logic [10:0] B_ACC  = 11'h010;
   localparam logic [10:0] B_SUB  = 11'h008;
   localparam logic [10:0] B_ADD  = 11'h004;
   localparam logic [10:0] B_AOE  = 11'h002;
   localparam logic [10:0] B_OUT  = 11'h001;

   localparam logic [10:0] S_F0  = B_PCOE | B_MAR;
   localparam logic [10:0] S_F1  = B_MEM | B_INC;
   localparam logic [10:0] S_A1M = B_MEM | B_MAR | B_INC;
   localparam logic [10:0] S_A1T = B_MEM | B_LDPC;
   localparam logic [10:0] S_A1N = B_MEM | B_INC;

   typedef struct packed {
      logic [15:0] idx;
      logic [10:0] s;
      logic [7:0]  ir;
   } exp_t;

   logic clk;
   logic clr;
   exp_t sb[$];
   int   n_vec;
   int   n_err;
   int   n_issued;

   ctrl_seq_if sb_if();

   ctrl_seq u_dut (
      .clk     (clk),
      .clr     (clr),
      .seq_bus (sb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive this cycle's inputs and queue the outputs expected for the state
   // entered at this edge. rst_mid asserts clr partway through the cycle.
   task automatic cyc(input logic r, input logic [7:0] md, input logic z,
                      input logic c, input logic ck, input logic [10:0] es,
                      input logic [7:0] eir, input logic rst_mid);
      exp_t e;
      @(posedge clk);
      #1;
      clr               = ck;
      sb_if.run         = r;
      sb_if.mem_data    = md;
      sb_if.zero_flag   = z;
      sb_if.carry_flag  = c;
      e.idx             = n_issued[15:0];
      e.s               = es;
      e.ir              = eir;
      sb.push_back(e);
      n_issued++;
      if (rst_mid) begin
         #2;
         clr = 1'b0;
      end
   endtask

   // F0 / F1 / DEC of one instruction with run held high.
   task automatic fetch(input logic [7:0] op, input logic [7:0] prev_ir);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0, prev_ir, 1'b0);
      cyc(1'b1, op,    1'b0, 1'b0, 1'b1, S_F1, prev_ir, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, NONE, op,      1'b0);
   endtask

   // Monitor: outputs are presented every cycle; compare at the falling edge.
   always @(negedge clk) begin
      logic [10:0] act;
      exp_t        e;
      act = {sb_if.halted, sb_if.pc_inc, sb_if.load_pc, sb_if.pc_oen, sb_if.mar_load,
             sb_if.mem_oen, sb_if.acc_load, sb_if.alu_op, sb_if.acc_oen, sb_if.out_load};
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         if (act !== e.s || sb_if.ir !== e.ir) begin
            n_err++;
            $display("FAIL vec%0d strobes/ir: got %b/%02h expected %b/%02h",
                     e.idx, act, sb_if.ir, e.s, e.ir);
         end
      end
      if ((32'(sb_if.pc_oen) + 32'(sb_if.mem_oen) + 32'(sb_if.acc_oen)) > 1) begin
         n_err++;
         $display("FAIL bus_onehot: got pc/mem/acc oen %b%b%b expected at most one",
                  sb_if.pc_oen, sb_if.mem_oen, sb_if.acc_oen);
      end
      if (sb_if.pc_inc && sb_if.load_pc) begin
         n_err++;
         $display("FAIL inc_load_excl: got pc_inc=1 load_pc=1 expected not both");
      end
      if (!sb_if.acc_load && sb_if.alu_op != 2'b00) begin
         n_err++;
         $display("FAIL alu_idle: got alu_op=%b expected 00 with acc_load=0", sb_if.alu_op);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0; n_issued = 0;
      clr = 1'b0;
      sb_if.run = 1'b0; sb_if.mem_data = 8'h00;
      sb_if.zero_flag = 1'b0; sb_if.carry_flag = 1'b0;

      // Reset state, then release with run=1.
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, NONE, 8'h00, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b0);
      // NOP stream over 00h memory.
      fetch(8'h00, 8'h00);
      fetch(8'h00, 8'h00);
      // Reset during F1 with 5Ah on the bus: ir must stay 00h.
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0, 8'h00, 1'b0);
      cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b1);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b0);
      // LDA 10h
      fetch(8'h10, 8'h00);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,          8'h10, 1'b0);
      cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, S_A1M,         8'h10, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, B_MEM | B_ACC, 8'h10, 1'b0);
      // ADD 10h
      fetch(8'h20, 8'h10);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,                  8'h20, 1'b0);
      cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, S_A1M,                 8'h20, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, B_MEM | B_ACC | B_ADD, 8'h20, 1'b0);
      // JZ taken, JZ not taken
      fetch(8'h60, 8'h20);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,  8'h60, 1'b0);
      cyc(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, S_A1T, 8'h60, 1'b0);
      fetch(8'h60, 8'h60);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,  8'h60, 1'b0);
      cyc(1'b1, 8'h08, 1'b0, 1'b1, 1'b1, S_A1N, 8'h60, 1'b0);
      // JC taken, JC not taken (zero_flag must not matter)
      fetch(8'h70, 8'h60);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,  8'h70, 1'b0);
      cyc(1'b1, 8'h08, 1'b0, 1'b1, 1'b1, S_A1T, 8'h70, 1'b0);
      fetch(8'h70, 8'h70);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,  8'h70, 1'b0);
      cyc(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, S_A1N, 8'h70, 1'b0);
      // JMP unconditional with both flags clear
      fetch(8'h50, 8'h70);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,  8'h50, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_A1T, 8'h50, 1'b0);
      // OUT
      fetch(8'h40, 8'h50);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, B_AOE | B_OUT, 8'h40, 1'b0);
      // Undefined opcode behaves as NOP
      fetch(8'hA3, 8'h40);
      // SUB with run dropped in M0: finish, then park in IDLE
      fetch(8'h30, 8'hA3);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, S_F0,                  8'h30, 1'b0);
      cyc(1'b1, 8'h10, 1'b0, 1'b0, 1'b1, S_A1M,                 8'h30, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, B_MEM | B_ACC | B_SUB, 8'h30, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, NONE,                  8'h30, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, NONE,                  8'h30, 1'b0);
      cyc(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, NONE,                  8'h30, 1'b0);
      // HLT: HALT held for 20 cycles while run toggles
      fetch(8'hF0, 8'h30);
      for (int i = 0; i < 20; i++)
         cyc(i[0], 8'h00, 1'b0, 1'b0, 1'b1, B_HALT, 8'hF0, 1'b0);
      // Reset clears HALT
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, NONE, 8'h00, 1'b0);

      repeat (3) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
